// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution MAC datapath: walks every output window,
// drives X/F read addresses, accumulator strobes and the y valid/ready handshake.
module conv_seq_ctrl #(
  parameter int X_SIZE  = 128,
  parameter int F_SIZE  = 32,
  parameter int XA_W    = $clog2(X_SIZE),
  parameter int FA_W    = $clog2(F_SIZE),
  parameter int NUM_OUT = X_SIZE - F_SIZE + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               conv_start,
  input  logic                               m_ready_y,
  output logic [XA_W-1:0]                    x_rd_addr,
  output logic [FA_W-1:0]                    f_rd_addr,
  output logic                               reset_accum,
  output logic                               en_accum,
  output logic                               m_valid_y,
  output logic [$clog2(NUM_OUT+1)-1:0]       out_idx,
  output logic                               busy,
  output logic                               conv_done
);

  localparam int OI_W = $clog2(NUM_OUT + 1);

  localparam logic [FA_W-1:0] TAP_ZERO = FA_W'(0);
  localparam logic [FA_W-1:0] TAP_ONE  = FA_W'(1);
  localparam logic [FA_W-1:0] TAP_TWO  = FA_W'(2);
  localparam logic [FA_W-1:0] F_LAST   = FA_W'(F_SIZE - 1);
  localparam logic [FA_W-1:0] F_PEN    = FA_W'(F_SIZE - 2);
  localparam logic [OI_W-1:0] IDX_ZERO = OI_W'(0);
  localparam logic [OI_W-1:0] IDX_ONE  = OI_W'(1);
  localparam logic [OI_W-1:0] IDX_LAST = OI_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          state_r;
  logic [FA_W-1:0] t_r;

  // X address of a given tap inside a window; never exceeds X_SIZE-1.
  function automatic logic [XA_W-1:0] x_addr_f(input logic [OI_W-1:0] idx,
                                                input logic [FA_W-1:0] tap);
    return XA_W'(idx) + XA_W'(tap);
  endfunction

  // Tap to address in the MAC cycle after tap t; clamps at the final tap.
  function automatic logic [FA_W-1:0] next_tap_f(input logic [FA_W-1:0] t);
    logic [FA_W-1:0] nt;
    if (t == F_PEN) begin
      nt = F_LAST;
    end else begin
      nt = t + TAP_TWO;
    end
    return nt;
  endfunction

  // Sequencer FSM; every output is a register loaded alongside the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      t_r         <= TAP_ZERO;
      out_idx     <= IDX_ZERO;
      x_rd_addr   <= '0;
      f_rd_addr   <= TAP_ZERO;
      reset_accum <= 1'b0;
      en_accum    <= 1'b0;
      m_valid_y   <= 1'b0;
      busy        <= 1'b0;
      conv_done   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (conv_start) begin
            state_r     <= ST_LOAD;
            out_idx     <= IDX_ZERO;
            busy        <= 1'b1;
            reset_accum <= 1'b1;
            x_rd_addr   <= x_addr_f(IDX_ZERO, TAP_ZERO);
            f_rd_addr   <= TAP_ZERO;
          end
        end
        ST_LOAD: begin
          state_r     <= ST_MAC;
          t_r         <= TAP_ZERO;
          reset_accum <= 1'b0;
          en_accum    <= 1'b1;
          x_rd_addr   <= x_addr_f(out_idx, TAP_ONE);
          f_rd_addr   <= TAP_ONE;
        end
        ST_MAC: begin
          if (t_r == F_LAST) begin
            state_r   <= ST_OUT;
            en_accum  <= 1'b0;
            m_valid_y <= 1'b1;
          end else begin
            t_r       <= t_r + TAP_ONE;
            x_rd_addr <= x_addr_f(out_idx, next_tap_f(t_r));
            f_rd_addr <= next_tap_f(t_r);
          end
        end
        ST_OUT: begin
          // accumulator is frozen here until the consumer takes the window
          if (m_ready_y) begin
            m_valid_y <= 1'b0;
            if (out_idx == IDX_LAST) begin
              state_r   <= ST_DONE;
              conv_done <= 1'b1;
            end else begin
              state_r     <= ST_LOAD;
              out_idx     <= out_idx + IDX_ONE;
              reset_accum <= 1'b1;
              x_rd_addr   <= x_addr_f(out_idx + IDX_ONE, TAP_ZERO);
              f_rd_addr   <= TAP_ZERO;
            end
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          conv_done <= 1'b0;
          busy      <= 1'b0;
          out_idx   <= IDX_ZERO;
        end
        default: begin
          state_r     <= ST_IDLE;
          t_r         <= TAP_ZERO;
          out_idx     <= IDX_ZERO;
          reset_accum <= 1'b0;
          en_accum    <= 1'b0;
          m_valid_y   <= 1'b0;
          busy        <= 1'b0;
          conv_done   <= 1'b0;
        end
      endcase
    end
  end

  conv_seq_ctrl_chk #(
    .X_SIZE  (X_SIZE),
    .XA_W    (XA_W),
    .NUM_OUT (NUM_OUT),
    .OI_W    (OI_W)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .m_ready_y   (m_ready_y),
    .x_rd_addr   (x_rd_addr),
    .reset_accum (reset_accum),
    .en_accum    (en_accum),
    .m_valid_y   (m_valid_y),
    .out_idx     (out_idx),
    .busy        (busy),
    .conv_done   (conv_done)
  );

endmodule

// Protocol properties of the sequencer outputs.
module conv_seq_ctrl_chk #(
  parameter int X_SIZE  = 128,
  parameter int XA_W    = 7,
  parameter int NUM_OUT = 97,
  parameter int OI_W    = 7
) (
  input logic            clk,
  input logic            reset,
  input logic            m_ready_y,
  input logic [XA_W-1:0] x_rd_addr,
  input logic            reset_accum,
  input logic            en_accum,
  input logic            m_valid_y,
  input logic [OI_W-1:0] out_idx,
  input logic            busy,
  input logic            conv_done
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
    !(reset_accum && en_accum))
    else $error("reset_accum and en_accum both high");

  a_valid_quiet: assert property (@(posedge clk) disable iff (!reset)
    m_valid_y |-> (!en_accum && !reset_accum))
    else $error("accumulator strobe while y valid");

  a_valid_hold: assert property (@(posedge clk) disable iff (!reset)
    (m_valid_y && !m_ready_y) |=> (m_valid_y && $stable(out_idx)))
    else $error("y valid dropped or index moved under backpressure");

  a_done_pulse: assert property (@(posedge clk) disable iff (!reset)
    conv_done |=> (!conv_done && !busy))
    else $error("conv_done not a single pulse into idle");

  a_idx_range: assert property (@(posedge clk) disable iff (!reset)
    int'(out_idx) < NUM_OUT)
    else $error("out_idx out of range");

  a_xaddr_range: assert property (@(posedge clk) disable iff (!reset)
    int'(x_rd_addr) < X_SIZE)
    else $error("x_rd_addr out of range");

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: default-size sequencing, backpressure, glitch,
// mid-run reset, plus a small configuration driving a reference memory/MAC model.
module tb_conv_seq_ctrl;

  localparam int BX = 128;
  localparam int BF = 32;
  localparam int BN = BX - BF + 1;
  localparam int BLAT = BF + 2;
  localparam int SX = 8;
  localparam int SF = 4;
  localparam int SN = SX - SF + 1;
  localparam int SLAT = SF + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       b_start = 1'b0, b_ready = 1'b0;
  logic [6:0] b_x;
  logic [4:0] b_f;
  logic       b_ra, b_en, b_valid, b_busy, b_done;
  logic [6:0] b_idx;

  logic       s_start = 1'b0, s_ready = 1'b0;
  logic [2:0] s_x;
  logic [1:0] s_f;
  logic       s_ra, s_en, s_valid, s_busy, s_done;
  logic [2:0] s_idx;

  conv_seq_ctrl #(.X_SIZE(BX), .F_SIZE(BF)) u_big (
    .clk(clk), .reset(reset), .conv_start(b_start), .m_ready_y(b_ready),
    .x_rd_addr(b_x), .f_rd_addr(b_f), .reset_accum(b_ra), .en_accum(b_en),
    .m_valid_y(b_valid), .out_idx(b_idx), .busy(b_busy), .conv_done(b_done)
  );

  conv_seq_ctrl #(.X_SIZE(SX), .F_SIZE(SF)) u_small (
    .clk(clk), .reset(reset), .conv_start(s_start), .m_ready_y(s_ready),
    .x_rd_addr(s_x), .f_rd_addr(s_f), .reset_accum(s_ra), .en_accum(s_en),
    .m_valid_y(s_valid), .out_idx(s_idx), .busy(s_busy), .conv_done(s_done)
  );

  // Reference memories (1-cycle read) and accumulator for the small instance.
  logic [7:0]  xmem [SX];
  logic [7:0]  fmem [SF];
  logic [7:0]  xd, fd;
  logic [15:0] acc;
  always @(posedge clk) begin
    xd <= xmem[s_x];
    fd <= fmem[s_f];
    if (s_ra) acc <= 16'd0;
    else if (s_en) acc <= acc + {8'd0, xd} * {8'd0, fd};
  end

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_big_zero(input string tag);
    check({tag, "_busy"}, b_busy, 0);
    check({tag, "_valid"}, b_valid, 0);
    check({tag, "_en"}, b_en, 0);
    check({tag, "_ra"}, b_ra, 0);
    check({tag, "_done"}, b_done, 0);
    check({tag, "_x"}, b_x, 0);
    check({tag, "_f"}, b_f, 0);
    check({tag, "_idx"}, b_idx, 0);
  endtask

  // x[i] = i+1, f = 1,2,3,4 -> y[k] = 10k + 30
  int exp_y [SN] = '{30, 40, 50, 60, 70};

  initial begin
    int ref_c, hs, stall, max_x;
    bit new_win, fin, exp_load, glitch_done, hit;

    for (int i = 0; i < SX; i++) xmem[i] = 8'(i + 1);
    for (int i = 0; i < SF; i++) fmem[i] = 8'(i + 1);

    repeat (3) tick;
    check_big_zero("rst");
    check("rst_s_busy", s_busy, 0);
    check("rst_s_valid", s_valid, 0);
    reset = 1'b1;
    tick;
    check("idle_busy", b_busy, 0);

    // ---------------- small configuration with reference MAC ----------------
    s_ready = 1'b1;
    s_start = 1'b1;
    ref_c = cyc; hs = 0; new_win = 1'b1; fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      tick;
      if (i == 0) s_start = 1'b0;
      if (s_done) begin
        check("s_hs_count", hs, SN);
        check("s_done_lat", cyc - ref_c, 1);
        fin = 1'b1;
      end else begin
        if (s_valid && new_win && hs < SN) begin
          check("s_lat", cyc - ref_c, SLAT);
          check("s_y", int'(acc), exp_y[hs]);
          check("s_idx", s_idx, hs);
          new_win = 1'b0;
        end
        if (s_valid && s_ready) begin
          hs++; ref_c = cyc; new_win = 1'b1;
        end
      end
    end
    check("s_done_seen", fin, 1);
    tick;
    check("s_after_busy", s_busy, 0);
    check("s_after_done", s_done, 0);

    // ---------------- default size: start timing ----------------
    b_ready = 1'b1;
    b_start = 1'b1;
    ref_c = cyc;
    tick;
    check("c1_ra", b_ra, 1);
    check("c1_x", b_x, 0);
    check("c1_f", b_f, 0);
    check("c1_busy", b_busy, 1);
    b_start = 1'b0;
    for (int c = 2; c <= 33; c++) begin
      tick;
      check("mac_en", b_en, 1);
      check("mac_f", b_f, (c - 1 > 31) ? 31 : c - 1);
    end
    tick;
    check("c34_valid", b_valid, 1);
    check("c34_idx", b_idx, 0);
    check("c34_en", b_en, 0);
    check("c34_lat", cyc - ref_c, BLAT);

    // ---------------- full run with backpressure and start glitch ----------------
    hs = 0; stall = 0; max_x = 0; new_win = 1'b0; exp_load = 1'b0;
    fin = 1'b0; glitch_done = 1'b0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      if (int'(b_x) > max_x) max_x = int'(b_x);
      if (exp_load) begin
        check("win_load", b_ra, 1);
        check("win_x", b_x, hs);
        check("win_f", b_f, 0);
        exp_load = 1'b0;
      end
      if (b_valid && new_win) begin
        check("win_lat", cyc - ref_c, BLAT);
        check("win_idx", b_idx, hs);
        new_win = 1'b0;
      end
      if (b_valid && hs == 5) begin
        check("bp_en", b_en, 0);
        check("bp_idx", b_idx, 5);
        stall++;
      end
      b_ready = !(hs == 5 && stall <= 10);
      if (hs == 10 && b_en && !glitch_done) begin
        b_start = 1'b1; glitch_done = 1'b1;
      end else begin
        b_start = 1'b0;
      end
      if (b_valid && b_ready) begin
        hs++; ref_c = cyc;
        new_win = (hs < BN);
        exp_load = (hs < BN);
      end
      tick;
      if (hs == BN) begin
        check("done_pulse", b_done, 1);
        check("done_valid", b_valid, 0);
        fin = 1'b1;
      end
    end
    b_start = 1'b0;
    b_ready = 1'b1;
    check("hs_count", hs, BN);
    check("bp_out_cycles", stall, 11);
    check("max_x", max_x, BX - 1);
    tick;
    check("end_busy", b_busy, 0);
    check("end_done", b_done, 0);

    // ---------------- mid-run reset during window 3, t=12 ----------------
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    hs = 0; hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (hs == 3 && b_en && b_f == 5'd13) begin
        hit = 1'b1;
      end else begin
        if (b_valid && b_ready) hs++;
        tick;
      end
    end
    check("mr_reached", hit, 1);
    check("mr_busy_before", b_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_big_zero("mr");
    repeat (3) begin
      tick;
      check("mr_no_done", b_done, 0);
    end
    reset = 1'b1;
    b_start = 1'b1;
    ref_c = cyc;
    tick;
    b_start = 1'b0;
    check("rs_ra", b_ra, 1);
    check("rs_idx", b_idx, 0);
    check("rs_x", b_x, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick;
      if (b_valid) hit = 1'b1;
    end
    check("rs_valid_seen", hit, 1);
    check("rs_lat", cyc - ref_c, BLAT);
    check("rs_out_idx", b_idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
